dmem_req_ctrl: RTL and testbench
================================

Name: dmem_req_ctrl

Overview:
- Write/request side of the data-memory path. Takes the load/store decoded in EX and drives an SRAM-like request interface (req/addr_ok/data_ok).
- Formats byte lanes and replicated write data for sb/sh/sw, sized requests for lb/lbu/lh/lhu/lw, and raw read data returned to MEM.
- Holds the pipeline through stallreq until the access completes. Sits between the EX stage and the data bus bridge.

Parameters:
- AW, 32, address width.
- DW, 32, data width; fixed at 32 for byte-lane logic.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  EX holds a valid instruction
- ex_op_store  in  3  one-hot {sw,sh,sb}, bit0=sb
- ex_op_load  in  5  one-hot {lhu,lh,lbu,lb,lw}, bit0=lw
- ex_addr  in  32  effective address
- ex_wdata  in  32  rt value for stores
- stall_mem  in  1  MEM stage held by a later stage
- req  out  1  request valid
- wr  out  1  1=store, 0=load
- size  out  2  0=byte, 1=half, 2=word
- addr  out  32  request address, unmodified
- wstrb  out  4  byte enables, 0 for loads
- wdata  out  32  lane-replicated store data
- addr_ok  in  1  request accepted
- data_ok  in  1  read data valid / write complete
- rdata  in  32  read data
- stallreq  out  1  stall request to pipeline controller
- rdata_out  out  32  latched raw read data to MEM
- rdata_valid  out  1  rdata_out holds completed access data

Behaviour:
- Access = ex_valid & (|ex_op_store | |ex_op_load).
- States IDLE, REQ, WAIT, DONE. Reset: IDLE. All outputs 0 at reset: req, wr, size, addr, wstrb, wdata, stallreq, rdata_out, rdata_valid.
- IDLE:
  - On access, latch wr/size/addr/wstrb/wdata into request registers, then go to REQ next cycle.
  - stallreq = access (combinational).
  - data_ok is ignored in IDLE.
- REQ:
  - req=1; request registers drive the bus unchanged.
  - addr_ok=1 → WAIT. Otherwise stay in REQ and hold all fields stable.
  - stallreq=1.
- WAIT:
  - req=0.
  - data_ok=1 → rdata_out<=rdata (loads only; stores leave it unchanged) and go to DONE.
  - stallreq=1. addr_ok and data_ok never occur in the same cycle.
- DONE:
  - stallreq=0, rdata_valid=1.
  - stall_mem=0 → IDLE next cycle; rdata_valid falls.
  - stall_mem=1 → stay in DONE and hold rdata_out.
- Latency: minimum 3 cycles of stallreq for an access whose addr_ok arrives in the first REQ cycle and data_ok the next cycle. Exactly one access per instruction; the instruction is never re-issued.
- Lane rules (a=ex_addr[1:0]):
  - sb: wstrb=4'b0001<<a; wdata={4{ex_wdata[7:0]}}; size=0.
  - sh: wstrb = a[1] ? 4'b1100 : 4'b0011; wdata={2{ex_wdata[15:0]}}; size=1.
  - sw: wstrb=4'b1111; wdata=ex_wdata; size=2.
  - lb/lbu: size=0. lh/lhu: size=1. lw: size=2. wstrb=0 for all loads.
- Simultaneous events: a new access is taken in IDLE only; EX is frozen by stallreq through REQ and WAIT.
- Reset mid-operation: return to IDLE in the next cycle and drop req. A late data_ok after reset is ignored.
- Misaligned sh/sw/lh/lhu/lw without the feature: issued as-is; behaviour is undefined downstream.

Optional Feature:
- DMEM_ALIGN_CHECK_EN: adds output adel (1) and ades (1).
  - A misaligned load (lh/lhu with a[0]=1, lw with a!=0) sets adel; a misaligned store sets ades. Both are asserted combinationally in IDLE.
  - No request is issued and the state stays IDLE. stallreq=0 for that instruction.
- Without the macro: no alignment check and no adel/ades ports.

Test Plan:
- sb, ex_addr=0x1000_0002, ex_wdata=0x0000_00A5, addr_ok on first REQ cycle, data_ok next cycle → req=1 for 1 cycle, wstrb=4'b0100, wdata=0xA5A5A5A5, size=0, wr=1, stallreq high for 3 cycles.
- lw, ex_addr=0x1000_0000, addr_ok delayed 3 cycles, rdata=0xDEADBEEF at data_ok → req and fields stable across the wait, rdata_out=0xDEADBEEF, rdata_valid=1 in DONE.
- sh, ex_addr=0x1000_0006, ex_wdata=0x1234_5678 → wstrb=4'b1100, wdata=0x56785678, size=1.
- lb completes while stall_mem=1 for 2 cycles → state held in DONE, rdata_out held, stallreq=0; IDLE on the cycle after stall_mem falls.
- rst asserted in WAIT, then data_ok=1 → state IDLE, req=0, rdata_out=0, rdata_valid=0.
- DMEM_ALIGN_CHECK_EN: sw with ex_addr=0x1000_0001 → ades=1, req never asserts, stallreq=0.

Source files
------------

// File: rtl/dmem_req_ctrl_if.sv
// SRAM-like data-memory request bus between the request controller (master)
// and the data bus bridge (slave).
interface dmem_req_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [AW-1:0]     addr;
    logic [DW/8-1:0]   wstrb;
    logic [DW-1:0]     wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DW-1:0]     rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/dmem_req_ctrl.sv
// EX-side data-memory request controller: formats lanes, runs the req/addr_ok/data_ok
// handshake and stalls the pipeline until the access completes. Optional DMEM_ALIGN_CHECK_EN.
module dmem_req_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid_i,
    input  logic [2:0]            ex_op_store_i,
    input  logic [4:0]            ex_op_load_i,
    input  logic [AW-1:0]         ex_addr_i,
    input  logic [DW-1:0]         ex_wdata_i,
    input  logic                  stall_mem_i,
    dmem_req_ctrl_if.master       bus,
    output logic                  stallreq_o,
    output logic [DW-1:0]         rdata_out_o,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic                  adel_o,
    output logic                  ades_o,
`endif
    output logic                  rdata_valid_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e          state_q, state_d;
    logic            wr_q;
    logic [1:0]      size_q;
    logic [AW-1:0]   addr_q;
    logic [3:0]      wstrb_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata_q;

    logic            access;
    logic            misaligned;
    logic            take;
    logic            capture;
    logic [1:0]      newSize;
    logic [3:0]      newWstrb;
    logic [DW-1:0]   newWdata;
    logic [1:0]      a;

    assign a      = ex_addr_i[1:0];
    assign access = ex_valid_i & ((|ex_op_store_i) | (|ex_op_load_i));

`ifdef DMEM_ALIGN_CHECK_EN
    logic misLoad, misStore;
    assign misLoad    = ex_valid_i & (((ex_op_load_i[3] | ex_op_load_i[4]) & a[0])
                                      | (ex_op_load_i[0] & (|a)));
    assign misStore   = ex_valid_i & ((ex_op_store_i[1] & a[0])
                                      | (ex_op_store_i[2] & (|a)));
    assign adel_o     = (state_q == IDLE) & misLoad;
    assign ades_o     = (state_q == IDLE) & misStore;
    assign misaligned = misLoad | misStore;
`else
    assign misaligned = 1'b0;
`endif

    // Store data is replicated across lanes so the bridge can pass it straight to SRAM.
    always_comb begin
        newSize  = 2'd0;
        newWstrb = 4'b0000;
        newWdata = '0;
        if (|ex_op_store_i) begin
            if (ex_op_store_i[0]) begin
                newSize  = 2'd0;
                newWstrb = 4'b0001 << a;
                newWdata = {4{ex_wdata_i[7:0]}};
            end else if (ex_op_store_i[1]) begin
                newSize  = 2'd1;
                newWstrb = a[1] ? 4'b1100 : 4'b0011;
                newWdata = {2{ex_wdata_i[15:0]}};
            end else begin
                newSize  = 2'd2;
                newWstrb = 4'b1111;
                newWdata = ex_wdata_i;
            end
        end else if (ex_op_load_i[0]) begin
            newSize = 2'd2;
        end else if (ex_op_load_i[3] | ex_op_load_i[4]) begin
            newSize = 2'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        take       = 1'b0;
        capture    = 1'b0;
        stallreq_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && !misaligned) begin
                    take       = 1'b1;
                    stallreq_o = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                stallreq_o = 1'b1;
                if (bus.addr_ok) state_d = WAIT;
            end
            WAIT: begin
                stallreq_o = 1'b1;
                if (bus.data_ok) begin
                    capture = ~wr_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!stall_mem_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wstrb_q <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                wr_q    <= |ex_op_store_i;
                size_q  <= newSize;
                addr_q  <= ex_addr_i;
                wstrb_q <= newWstrb;
                wdata_q <= newWdata;
            end
            if (capture) rdata_q <= bus.rdata;
        end
    end

    // Request fields come straight from registers so they stay stable while req waits.
    assign bus.req       = (state_q == REQ);
    assign bus.wr        = wr_q;
    assign bus.size      = size_q;
    assign bus.addr      = addr_q;
    assign bus.wstrb     = wstrb_q;
    assign bus.wdata     = wdata_q;
    assign rdata_out_o   = rdata_q;
    assign rdata_valid_o = (state_q == DONE);

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed bench for dmem_req_ctrl: expected bus requests are queued when an access is
// driven and popped when the DUT raises req; the bench plays the memory side.
module tb_dmem_req_ctrl;

    localparam logic [2:0] OP_SB  = 3'b001;
    localparam logic [2:0] OP_SH  = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b100;
    localparam logic [4:0] OP_LW  = 5'b00001;
    localparam logic [4:0] OP_LB  = 5'b00010;
    localparam logic [4:0] OP_LBU = 5'b00100;
    localparam logic [4:0] OP_LH  = 5'b01000;
    localparam logic [4:0] OP_LHU = 5'b10000;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } reqT;

    logic        clk = 1'b0;
    logic        rst;
    logic        exValid;
    logic [2:0]  exOpStore;
    logic [4:0]  exOpLoad;
    logic [31:0] exAddr;
    logic [31:0] exWdata;
    logic        stallMem;
    logic        stallreq;
    logic [31:0] rdataOut;
    logic        rdataValid;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        adel;
    logic        ades;
`endif

    int          checks = 0;
    int          errors = 0;
    reqT         sbq[$];
    logic [31:0] lastRd;

    dmem_req_ctrl_if #(.AW(32), .DW(32)) bus ();

    dmem_req_ctrl #(.AW(32), .DW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid_i    (exValid),
        .ex_op_store_i (exOpStore),
        .ex_op_load_i  (exOpLoad),
        .ex_addr_i     (exAddr),
        .ex_wdata_i    (exWdata),
        .stall_mem_i   (stallMem),
        .bus           (bus),
        .stallreq_o    (stallreq),
        .rdata_out_o   (rdataOut),
`ifdef DMEM_ALIGN_CHECK_EN
        .adel_o        (adel),
        .ades_o        (ades),
`endif
        .rdata_valid_o (rdataValid)
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected request for a decoded EX op, written from the lane table.
    function automatic reqT model(input logic [2:0] st, input logic [4:0] ld,
                                  input logic [31:0] ad, input logic [31:0] wd);
        reqT r;
        r.wr    = (st != 3'b000);
        r.addr  = ad;
        r.size  = 2'd0;
        r.wstrb = 4'b0000;
        r.wdata = 32'h0;
        if (st == OP_SB) begin
            case (ad[1:0])
                2'd0: r.wstrb = 4'b0001;
                2'd1: r.wstrb = 4'b0010;
                2'd2: r.wstrb = 4'b0100;
                default: r.wstrb = 4'b1000;
            endcase
            r.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        end else if (st == OP_SH) begin
            r.size  = 2'd1;
            r.wstrb = ad[1] ? 4'b1100 : 4'b0011;
            r.wdata = {wd[15:0], wd[15:0]};
        end else if (st == OP_SW) begin
            r.size  = 2'd2;
            r.wstrb = 4'b1111;
            r.wdata = wd;
        end else if (ld == OP_LW) begin
            r.size = 2'd2;
        end else if (ld == OP_LH || ld == OP_LHU) begin
            r.size = 2'd1;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full access: IDLE issue, REQ with addr_ok after aokDly cycles, WAIT with
    // data_ok after dokDly cycles, then DONE held by stall_mem for stallCycles cycles.
    task automatic applyStimulus(input logic [2:0] st, input logic [4:0] ld,
                                 input logic [31:0] ad, input logic [31:0] wd,
                                 input logic [31:0] resp, input int aokDly,
                                 input int dokDly, input int stallCycles, input int expStall);
        reqT e;
        int  stallCnt = 0;
        int  reqCnt   = 0;
        exValid   = 1'b1;
        exOpStore = st;
        exOpLoad  = ld;
        exAddr    = ad;
        exWdata   = wd;
        sbq.push_back(model(st, ld, ad, wd));
        #1;
        checkOutput("idle_req", {31'b0, bus.req}, 32'd0);
        if (stallreq) stallCnt++;
        tick();
        for (int i = 0; i <= aokDly; i++) begin
            if (bus.req) reqCnt++;
            if (stallreq) stallCnt++;
            if (i == 0) e = sbq.pop_front();
            checkOutput("req_wr", {31'b0, bus.wr}, {31'b0, e.wr});
            checkOutput("req_size", {30'b0, bus.size}, {30'b0, e.size});
            checkOutput("req_addr", bus.addr, e.addr);
            checkOutput("req_wstrb", {28'b0, bus.wstrb}, {28'b0, e.wstrb});
            checkOutput("req_wdata", bus.wdata, e.wdata);
            bus.addr_ok = (i == aokDly);
            tick();
        end
        bus.addr_ok = 1'b0;
        for (int i = 0; i <= dokDly; i++) begin
            checkOutput("wait_req", {31'b0, bus.req}, 32'd0);
            if (stallreq) stallCnt++;
            bus.data_ok = (i == dokDly);
            bus.rdata   = (i == dokDly) ? resp : 32'hBAD0_BAD0;
            tick();
        end
        bus.data_ok = 1'b0;
        bus.rdata   = 32'h0BAD_F00D;
        if (st == 3'b000) lastRd = resp;
        exValid   = 1'b0;
        exOpStore = 3'b000;
        exOpLoad  = 5'b00000;
        checkOutput("stall_cycles", stallCnt, expStall);
        checkOutput("req_cycles", reqCnt, aokDly + 1);
        for (int i = 0; i <= stallCycles; i++) begin
            stallMem = (i < stallCycles);
            checkOutput("done_valid", {31'b0, rdataValid}, 32'd1);
            checkOutput("done_stallreq", {31'b0, stallreq}, 32'd0);
            checkOutput("done_rdata", rdataOut, lastRd);
            tick();
        end
        stallMem = 1'b0;
        checkOutput("after_valid", {31'b0, rdataValid}, 32'd0);
        checkOutput("after_req", {31'b0, bus.req}, 32'd0);
        checkOutput("after_rdata", rdataOut, lastRd);
    endtask

    // Directed sequence: reset, lane formatting, stalls, reset mid-access, options.
    initial begin
        rst          = 1'b1;
        exValid      = 1'b0;
        exOpStore    = 3'b000;
        exOpLoad     = 5'b00000;
        exAddr       = 32'h0;
        exWdata      = 32'h0;
        stallMem     = 1'b0;
        bus.addr_ok  = 1'b0;
        bus.data_ok  = 1'b0;
        bus.rdata    = 32'h0;
        lastRd       = 32'h0;
        tick();
        tick();
        checkOutput("rst_req", {31'b0, bus.req}, 32'd0);
        checkOutput("rst_wr", {31'b0, bus.wr}, 32'd0);
        checkOutput("rst_size", {30'b0, bus.size}, 32'd0);
        checkOutput("rst_addr", bus.addr, 32'd0);
        checkOutput("rst_wstrb", {28'b0, bus.wstrb}, 32'd0);
        checkOutput("rst_wdata", bus.wdata, 32'd0);
        checkOutput("rst_stallreq", {31'b0, stallreq}, 32'd0);
        checkOutput("rst_rdata", rdataOut, 32'd0);
        checkOutput("rst_valid", {31'b0, rdataValid}, 32'd0);
        rst = 1'b0;
        tick();

        applyStimulus(OP_SB, 5'b0, 32'h1000_0002, 32'h0000_00A5, 32'h0, 0, 0, 0, 3);
        applyStimulus(3'b0, OP_LW, 32'h1000_0000, 32'h0, 32'hDEAD_BEEF, 3, 0, 0, 6);
        applyStimulus(OP_SH, 5'b0, 32'h1000_0006, 32'h1234_5678, 32'h0, 1, 2, 0, 6);
        applyStimulus(OP_SH, 5'b0, 32'h1000_0004, 32'hCAFE_1357, 32'h0, 0, 1, 0, 4);
        applyStimulus(3'b0, OP_LB, 32'h1000_0003, 32'h0, 32'h8899_AABB, 0, 2, 2, 5);
        applyStimulus(OP_SB, 5'b0, 32'h2000_0001, 32'hFFFF_FF3C, 32'h0, 0, 0, 1, 3);
        applyStimulus(OP_SW, 5'b0, 32'h2000_0008, 32'h0102_0304, 32'h0, 2, 1, 0, 6);
        applyStimulus(3'b0, OP_LHU, 32'h3000_0002, 32'h0, 32'h7777_1111, 0, 0, 0, 3);
        applyStimulus(3'b0, OP_LBU, 32'h3000_0001, 32'h0, 32'h0000_00F0, 1, 0, 0, 4);
        applyStimulus(3'b0, OP_LH, 32'h3000_0000, 32'h0, 32'h5A5A_A5A5, 0, 1, 0, 4);

        // Valid instruction with no memory op, and a memory op without ex_valid.
        exValid = 1'b1;
        #1;
        checkOutput("nop_stallreq", {31'b0, stallreq}, 32'd0);
        tick();
        checkOutput("nop_req", {31'b0, bus.req}, 32'd0);
        exValid   = 1'b0;
        exOpStore = OP_SW;
        #1;
        checkOutput("novalid_stallreq", {31'b0, stallreq}, 32'd0);
        tick();
        checkOutput("novalid_req", {31'b0, bus.req}, 32'd0);
        exOpStore = 3'b000;

        // Reset while in WAIT, then a late data_ok that must be ignored.
        exValid  = 1'b1;
        exOpLoad = OP_LW;
        exAddr   = 32'h1000_0010;
        sbq.push_back(model(3'b0, OP_LW, 32'h1000_0010, 32'h0));
        tick();
        begin
            reqT e;
            e = sbq.pop_front();
            checkOutput("rstw_req", {31'b0, bus.req}, 32'd1);
            checkOutput("rstw_addr", bus.addr, e.addr);
        end
        bus.addr_ok = 1'b1;
        tick();
        bus.addr_ok = 1'b0;
        checkOutput("rstw_wait_stall", {31'b0, stallreq}, 32'd1);
        rst      = 1'b1;
        exValid  = 1'b0;
        exOpLoad = 5'b00000;
        tick();
        rst         = 1'b0;
        lastRd      = 32'h0;
        bus.data_ok = 1'b1;
        bus.rdata   = 32'hCAFE_F00D;
        checkOutput("rstw_req0", {31'b0, bus.req}, 32'd0);
        checkOutput("rstw_rdata0", rdataOut, 32'd0);
        checkOutput("rstw_valid0", {31'b0, rdataValid}, 32'd0);
        checkOutput("rstw_stall0", {31'b0, stallreq}, 32'd0);
        tick();
        bus.data_ok = 1'b0;
        checkOutput("late_rdata", rdataOut, 32'd0);
        checkOutput("late_valid", {31'b0, rdataValid}, 32'd0);
        checkOutput("late_req", {31'b0, bus.req}, 32'd0);
        tick();

`ifdef DMEM_ALIGN_CHECK_EN
        exValid   = 1'b1;
        exOpStore = OP_SW;
        exAddr    = 32'h1000_0001;
        #1;
        checkOutput("ades_set", {31'b0, ades}, 32'd1);
        checkOutput("ades_adel", {31'b0, adel}, 32'd0);
        checkOutput("ades_stall", {31'b0, stallreq}, 32'd0);
        tick();
        checkOutput("ades_noreq", {31'b0, bus.req}, 32'd0);
        tick();
        checkOutput("ades_noreq2", {31'b0, bus.req}, 32'd0);
        exOpStore = 3'b000;
        exOpLoad  = OP_LH;
        exAddr    = 32'h1000_0003;
        #1;
        checkOutput("adel_set", {31'b0, adel}, 32'd1);
        checkOutput("adel_ades", {31'b0, ades}, 32'd0);
        checkOutput("adel_stall", {31'b0, stallreq}, 32'd0);
        tick();
        checkOutput("adel_noreq", {31'b0, bus.req}, 32'd0);
        exValid  = 1'b0;
        exOpLoad = 5'b00000;
        tick();
        applyStimulus(3'b0, OP_LW, 32'h1000_0004, 32'h0, 32'h1357_9BDF, 0, 0, 0, 3);
`else
        applyStimulus(3'b0, OP_LW, 32'h1000_0002, 32'h0, 32'h2468_ACE0, 0, 0, 0, 3);
        applyStimulus(OP_SW, 5'b0, 32'h1000_0003, 32'hA1B2_C3D4, 32'h0, 0, 0, 0, 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
